// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fetch_unit                                               |
// | Description : Instruction fetch stage. Owns the PC, reads instruction  |
// |               words over a req/ack handshake into IR and applies       |
// |               jump/call/ret redirects. Optional return-address stack   |
// |               enabled by defining FETCH_RAS_EN.                        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module fetch_unit #(
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                RAS_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ir_load,
   input  logic              jump,
   input  logic              call,
   input  logic              ret,
   input  logic [ADDR_W-1:0] target,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       IR,
   output logic              ir_valid,
   output logic              busy,
   output logic [ADDR_W-1:0] pc,
   output logic              ras_ovf,
   output logic              ras_unf
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
   typedef enum logic [1:0] {K_JUMP = 2'd0, K_CALL = 2'd1, K_RET = 2'd2} kind_t;

   state_t              r_state, w_state_next;
   logic [ADDR_W-1:0]   r_pc, w_pc_next;
   logic [31:0]         r_ir, w_ir_next;
   logic                r_ir_valid, w_ir_valid_next;
   logic                r_mem_req, w_mem_req_next;
   logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
   logic                r_pend_fetch, w_pend_fetch_next;
   logic                r_pend_redir, w_pend_redir_next;
   kind_t               r_pend_kind, w_pend_kind_next;
   logic [ADDR_W-1:0]   r_pend_target, w_pend_target_next;

   logic                w_req_valid;
   kind_t               w_req_kind;
   logic                w_apply;
   kind_t               w_apply_kind;
   logic [ADDR_W-1:0]   w_apply_target;

`ifdef FETCH_RAS_EN
   localparam int                c_SP_W = $clog2(RAS_DEPTH);
   localparam logic [c_SP_W:0]   c_FULL = (c_SP_W+1)'(RAS_DEPTH);
   localparam logic [c_SP_W:0]   c_ONE  = 1;

   logic [ADDR_W-1:0]   r_ras [RAS_DEPTH];
   logic [c_SP_W:0]     r_ras_cnt;
   logic                r_ovf, r_unf;
   logic                w_push, w_pop, w_ovf_set, w_unf_set;

   // Request decode with fixed priority jump > call > ret
   always_comb begin
      w_req_valid = jump | call | ret;
      w_req_kind  = jump ? K_JUMP : (call ? K_CALL : K_RET);
   end
`else
   logic                w_unused;

   // Without a stack, call degenerates to jump and ret is dropped
   always_comb begin
      w_req_valid = jump | call;
      w_req_kind  = K_JUMP;
   end
   assign w_unused = ^{ret, RAS_DEPTH[0]};
`endif

   // Next-state, datapath and redirect resolution
   always_comb begin
      w_state_next       = r_state;
      w_pc_next          = r_pc;
      w_ir_next          = r_ir;
      w_ir_valid_next    = 1'b0;
      w_mem_req_next     = r_mem_req;
      w_mem_addr_next    = r_mem_addr;
      w_pend_fetch_next  = r_pend_fetch;
      w_pend_redir_next  = r_pend_redir;
      w_pend_kind_next   = r_pend_kind;
      w_pend_target_next = r_pend_target;
      w_apply            = 1'b0;
      w_apply_kind       = K_JUMP;
      w_apply_target     = target;
`ifdef FETCH_RAS_EN
      w_push             = 1'b0;
      w_pop              = 1'b0;
      w_ovf_set          = 1'b0;
      w_unf_set          = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_req_valid) begin
               // Redirect wins the edge; a coincident fetch waits one cycle
               w_apply           = 1'b1;
               w_apply_kind      = w_req_kind;
               w_apply_target    = target;
               w_pend_fetch_next = ir_load | r_pend_fetch;
            end else if (ir_load || r_pend_fetch) begin
               w_pend_fetch_next = 1'b0;
               w_mem_req_next    = 1'b1;
               w_mem_addr_next   = r_pc;
               w_state_next      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_req_valid) begin
               w_pend_redir_next  = 1'b1;
               w_pend_kind_next   = w_req_kind;
               w_pend_target_next = target;
            end
            if (mem_ack) begin
               w_ir_next         = mem_rdata;
               w_ir_valid_next   = 1'b1;
               w_mem_req_next    = 1'b0;
               w_pc_next         = r_pc + ADDR_W'(1);
               w_state_next      = S_IDLE;
               w_pend_redir_next = 1'b0;
               if (w_req_valid) begin
                  w_apply        = 1'b1;
                  w_apply_kind   = w_req_kind;
                  w_apply_target = target;
               end else if (r_pend_redir) begin
                  w_apply        = 1'b1;
                  w_apply_kind   = r_pend_kind;
                  w_apply_target = r_pend_target;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      // A ret on an empty stack leaves w_pc_next at its fall-through value
      if (w_apply) begin
         case (w_apply_kind)
            K_JUMP: w_pc_next = w_apply_target;
            K_CALL: begin
               w_pc_next = w_apply_target;
`ifdef FETCH_RAS_EN
               if (r_ras_cnt == c_FULL) w_ovf_set = 1'b1;
               else                     w_push    = 1'b1;
`endif
            end
            K_RET: begin
`ifdef FETCH_RAS_EN
               if (r_ras_cnt == '0) begin
                  w_unf_set = 1'b1;
               end else begin
                  w_pop     = 1'b1;
                  w_pc_next = r_ras[c_SP_W'(r_ras_cnt - c_ONE)];
               end
`endif
            end
            default: ;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_ir          <= '0;
         r_ir_valid    <= 1'b0;
         r_mem_req     <= 1'b0;
         r_mem_addr    <= '0;
         r_pend_fetch  <= 1'b0;
         r_pend_redir  <= 1'b0;
         r_pend_kind   <= K_JUMP;
         r_pend_target <= '0;
      end else begin
         r_pc          <= w_pc_next;
         r_ir          <= w_ir_next;
         r_ir_valid    <= w_ir_valid_next;
         r_mem_req     <= w_mem_req_next;
         r_mem_addr    <= w_mem_addr_next;
         r_pend_fetch  <= w_pend_fetch_next;
         r_pend_redir  <= w_pend_redir_next;
         r_pend_kind   <= w_pend_kind_next;
         r_pend_target <= w_pend_target_next;
      end
   end

`ifdef FETCH_RAS_EN
   // Return-address stack: the current PC is pushed, flags are sticky
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ras_cnt <= '0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
      end else begin
         if (w_push) begin
            r_ras[c_SP_W'(r_ras_cnt)] <= r_pc;
            r_ras_cnt                 <= r_ras_cnt + c_ONE;
         end else if (w_pop) begin
            r_ras_cnt <= r_ras_cnt - c_ONE;
         end
         if (w_ovf_set) r_ovf <= 1'b1;
         if (w_unf_set) r_unf <= 1'b1;
      end
   end

   assign ras_ovf = r_ovf;
   assign ras_unf = r_unf;
`else
   assign ras_ovf = 1'b0;
   assign ras_unf = 1'b0;
`endif

   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;
   assign IR       = r_ir;
   assign ir_valid = r_ir_valid;
   assign busy     = (r_state == S_WAIT);
   assign pc       = r_pc;

endmodule
`default_nettype wire
